// File: rtl/issue_queue_multi.sv
// Multi-port issue queue: CDB wakeup, dispatch-cycle bypass, per-FU issue handshakes and flush.
// Define IQ_AGE_SELECT_EN for oldest-first select; otherwise select is lowest-index.
module issue_queue_multi #(
  parameter int unsigned RS_DEPTH = 16,
  parameter int unsigned PREG_W   = 6,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned NUM_FU   = 3,
  parameter int unsigned NUM_CDB  = 3,
  parameter int unsigned OP_W     = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          flush,
  input  logic                          disp_valid,
  output logic                          disp_ready,
  input  logic [OP_W-1:0]               disp_op,
  input  logic [1:0]                    disp_fu,
  input  logic [PREG_W-1:0]             disp_rd,
  input  logic [PREG_W-1:0]             disp_rs1,
  input  logic [PREG_W-1:0]             disp_rs2,
  input  logic                          disp_rs1_rdy,
  input  logic                          disp_rs2_rdy,
  input  logic [DATA_W-1:0]             disp_rs1_val,
  input  logic [DATA_W-1:0]             disp_rs2_val,
  input  logic [DATA_W-1:0]             disp_imm,
  input  logic [NUM_CDB-1:0]            cdb_valid,
  input  logic [NUM_CDB*PREG_W-1:0]     cdb_tag,
  input  logic [NUM_CDB*DATA_W-1:0]     cdb_data,
  output logic [NUM_FU-1:0]             iss_valid,
  input  logic [NUM_FU-1:0]             iss_ready,
  output logic [NUM_FU*OP_W-1:0]        iss_op,
  output logic [NUM_FU*PREG_W-1:0]      iss_rd,
  output logic [NUM_FU*DATA_W-1:0]      iss_rs1_val,
  output logic [NUM_FU*DATA_W-1:0]      iss_rs2_val,
  output logic [NUM_FU*DATA_W-1:0]      iss_imm,
  output logic [$clog2(RS_DEPTH+1)-1:0] occupancy,
  output logic                          empty
);

  localparam int unsigned IDX_W = $clog2(RS_DEPTH);
  localparam int unsigned CNT_W = $clog2(RS_DEPTH + 1);

  logic [RS_DEPTH-1:0] ent_valid;
  logic [RS_DEPTH-1:0] ent_r1;
  logic [RS_DEPTH-1:0] ent_r2;
  logic [1:0]          ent_fu  [RS_DEPTH];
  logic [OP_W-1:0]     ent_op  [RS_DEPTH];
  logic [PREG_W-1:0]   ent_rd  [RS_DEPTH];
  logic [PREG_W-1:0]   ent_t1  [RS_DEPTH];
  logic [PREG_W-1:0]   ent_t2  [RS_DEPTH];
  logic [DATA_W-1:0]   ent_v1  [RS_DEPTH];
  logic [DATA_W-1:0]   ent_v2  [RS_DEPTH];
  logic [DATA_W-1:0]   ent_imm [RS_DEPTH];

`ifdef IQ_AGE_SELECT_EN
  // older[i][j] set means entry j was dispatched before entry i and is still resident
  logic [RS_DEPTH-1:0] older [RS_DEPTH];
`endif

  logic                disp_fire;
  logic [IDX_W-1:0]    alloc_idx;
  logic [DATA_W:0]     bp1;
  logic [DATA_W:0]     bp2;
  logic                new_r1;
  logic                new_r2;
  logic [DATA_W-1:0]   new_v1;
  logic [DATA_W-1:0]   new_v2;
  logic [DATA_W:0]     wm1 [RS_DEPTH];
  logic [DATA_W:0]     wm2 [RS_DEPTH];
  logic [RS_DEPTH-1:0] wk1;
  logic [RS_DEPTH-1:0] wk2;
  logic [RS_DEPTH-1:0] eligible;
  logic [RS_DEPTH-1:0] cand;
  logic [RS_DEPTH-1:0] oldest;
  logic [RS_DEPTH-1:0] freed;
  logic [NUM_FU-1:0]   load;
  logic [NUM_FU-1:0]   found;
  logic [IDX_W-1:0]    sel_idx [NUM_FU];
  logic [CNT_W-1:0]    num_iss;

  assign disp_ready = (occupancy != CNT_W'(RS_DEPTH)) && !flush;
  assign disp_fire  = disp_valid && disp_ready;
  assign empty      = (occupancy == '0);
  assign eligible   = ent_valid & ent_r1 & ent_r2;

  // {hit, data} for a tag against the CDB; the lowest matching port wins
  function automatic logic [DATA_W:0] cdb_match(input logic [PREG_W-1:0] tag);
    logic [DATA_W:0] res;
    res = '0;
    for (int k = NUM_CDB - 1; k >= 0; k--) begin
      if (cdb_valid[k] && (cdb_tag[k*PREG_W +: PREG_W] == tag)) begin
        res = {1'b1, cdb_data[k*DATA_W +: DATA_W]};
      end
    end
    return res;
  endfunction

  always_comb begin
    alloc_idx = '0;
    for (int i = RS_DEPTH - 1; i >= 0; i--) begin
      if (!ent_valid[i]) alloc_idx = IDX_W'(i);
    end
  end

  always_comb begin
    bp1    = cdb_match(disp_rs1);
    bp2    = cdb_match(disp_rs2);
    new_r1 = (disp_rs1 == '0) || bp1[DATA_W] || disp_rs1_rdy;
    new_r2 = (disp_rs2 == '0) || bp2[DATA_W] || disp_rs2_rdy;
    new_v1 = (disp_rs1 == '0) ? '0 : (bp1[DATA_W] ? bp1[DATA_W-1:0] : disp_rs1_val);
    new_v2 = (disp_rs2 == '0) ? '0 : (bp2[DATA_W] ? bp2[DATA_W-1:0] : disp_rs2_val);
  end

  always_comb begin
    wk1 = '0;
    wk2 = '0;
    for (int i = 0; i < RS_DEPTH; i++) begin
      wm1[i] = cdb_match(ent_t1[i]);
      wm2[i] = cdb_match(ent_t2[i]);
      wk1[i] = ent_valid[i] && !ent_r1[i] && wm1[i][DATA_W];
      wk2[i] = ent_valid[i] && !ent_r2[i] && wm2[i][DATA_W];
    end
  end

  always_comb begin
    found   = '0;
    load    = '0;
    freed   = '0;
    num_iss = '0;
    cand    = '0;
    oldest  = '0;
    for (int f = 0; f < NUM_FU; f++) begin
      sel_idx[f] = '0;
      load[f]    = !iss_valid[f] || iss_ready[f];
      for (int i = 0; i < RS_DEPTH; i++) begin
        cand[i] = eligible[i] && (ent_fu[i] == 2'(f));
      end
      oldest = cand;
`ifdef IQ_AGE_SELECT_EN
      for (int i = 0; i < RS_DEPTH; i++) begin
        oldest[i] = cand[i] && ((cand & older[i]) == '0);
      end
`endif
      for (int i = RS_DEPTH - 1; i >= 0; i--) begin
        if (oldest[i]) begin
          found[f]   = 1'b1;
          sel_idx[f] = IDX_W'(i);
        end
      end
      if (load[f] && found[f]) begin
        freed[sel_idx[f]] = 1'b1;
        num_iss           = num_iss + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ent_valid   <= '0;
      ent_r1      <= '0;
      ent_r2      <= '0;
      for (int i = 0; i < RS_DEPTH; i++) begin
        ent_fu[i]  <= '0;
        ent_op[i]  <= '0;
        ent_rd[i]  <= '0;
        ent_t1[i]  <= '0;
        ent_t2[i]  <= '0;
        ent_v1[i]  <= '0;
        ent_v2[i]  <= '0;
        ent_imm[i] <= '0;
      end
      iss_valid   <= '0;
      iss_op      <= '0;
      iss_rd      <= '0;
      iss_rs1_val <= '0;
      iss_rs2_val <= '0;
      iss_imm     <= '0;
      occupancy   <= '0;
    end else if (flush) begin
      ent_valid <= '0;
      iss_valid <= '0;
      occupancy <= '0;
    end else begin
      for (int i = 0; i < RS_DEPTH; i++) begin
        if (wk1[i]) begin
          ent_r1[i] <= 1'b1;
          ent_v1[i] <= wm1[i][DATA_W-1:0];
        end
        if (wk2[i]) begin
          ent_r2[i] <= 1'b1;
          ent_v2[i] <= wm2[i][DATA_W-1:0];
        end
      end
      for (int f = 0; f < NUM_FU; f++) begin
        if (load[f]) begin
          iss_valid[f] <= found[f];
          if (found[f]) begin
            iss_op[f*OP_W +: OP_W]          <= ent_op[sel_idx[f]];
            iss_rd[f*PREG_W +: PREG_W]      <= ent_rd[sel_idx[f]];
            iss_rs1_val[f*DATA_W +: DATA_W] <= ent_v1[sel_idx[f]];
            iss_rs2_val[f*DATA_W +: DATA_W] <= ent_v2[sel_idx[f]];
            iss_imm[f*DATA_W +: DATA_W]     <= ent_imm[sel_idx[f]];
          end
        end
      end
      ent_valid <= (ent_valid & ~freed) |
                   (disp_fire ? (RS_DEPTH'(1) << alloc_idx) : '0);
      if (disp_fire) begin
        ent_fu[alloc_idx]  <= disp_fu;
        ent_op[alloc_idx]  <= disp_op;
        ent_rd[alloc_idx]  <= disp_rd;
        ent_t1[alloc_idx]  <= disp_rs1;
        ent_t2[alloc_idx]  <= disp_rs2;
        ent_r1[alloc_idx]  <= new_r1;
        ent_r2[alloc_idx]  <= new_r2;
        ent_v1[alloc_idx]  <= new_v1;
        ent_v2[alloc_idx]  <= new_v2;
        ent_imm[alloc_idx] <= disp_imm;
      end
      occupancy <= occupancy + CNT_W'(disp_fire) - num_iss;
    end
  end

`ifdef IQ_AGE_SELECT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < RS_DEPTH; i++) older[i] <= '0;
    end else if (flush) begin
      for (int i = 0; i < RS_DEPTH; i++) older[i] <= '0;
    end else if (disp_fire) begin
      for (int j = 0; j < RS_DEPTH; j++) older[j][alloc_idx] <= 1'b0;
      older[alloc_idx] <= ent_valid;
    end
  end
`endif

  assert property (@(posedge clk) disable iff (rst) disp_fire |-> (32'(disp_fu) < NUM_FU));

endmodule

// File: tb/tb_issue_queue_multi.sv
// Bench for issue_queue_multi: directed scenarios plus random traffic against a slot-level model.
module tb_issue_queue_multi;

  localparam int D  = 16;
  localparam int PW = 6;
  localparam int DW = 32;
  localparam int NF = 3;
  localparam int NC = 3;
  localparam int OW = 4;
`ifdef IQ_AGE_SELECT_EN
  localparam bit AGE = 1'b1;
`else
  localparam bit AGE = 1'b0;
`endif

  logic clk, rst, flush;
  logic disp_valid, disp_ready;
  logic [OW-1:0] disp_op;
  logic [1:0] disp_fu;
  logic [PW-1:0] disp_rd, disp_rs1, disp_rs2;
  logic disp_rs1_rdy, disp_rs2_rdy;
  logic [DW-1:0] disp_rs1_val, disp_rs2_val, disp_imm;
  logic [NC-1:0] cdb_valid;
  logic [NC*PW-1:0] cdb_tag;
  logic [NC*DW-1:0] cdb_data;
  logic [NF-1:0] iss_valid, iss_ready;
  logic [NF*OW-1:0] iss_op;
  logic [NF*PW-1:0] iss_rd;
  logic [NF*DW-1:0] iss_rs1_val, iss_rs2_val, iss_imm;
  logic [4:0] occupancy;
  logic empty;

  issue_queue_multi #(
    .RS_DEPTH(D), .PREG_W(PW), .DATA_W(DW), .NUM_FU(NF), .NUM_CDB(NC), .OP_W(OW)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_op(disp_op), .disp_fu(disp_fu),
    .disp_rd(disp_rd), .disp_rs1(disp_rs1), .disp_rs2(disp_rs2),
    .disp_rs1_rdy(disp_rs1_rdy), .disp_rs2_rdy(disp_rs2_rdy),
    .disp_rs1_val(disp_rs1_val), .disp_rs2_val(disp_rs2_val), .disp_imm(disp_imm),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_op(iss_op), .iss_rd(iss_rd),
    .iss_rs1_val(iss_rs1_val), .iss_rs2_val(iss_rs2_val), .iss_imm(iss_imm),
    .occupancy(occupancy), .empty(empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: slot contents, dispatch order, and what each issue port holds
  bit          m_valid[D];
  int          m_fu[D];
  logic [OW-1:0] m_op[D];
  logic [PW-1:0] m_rd[D], m_t1[D], m_t2[D];
  bit          m_r1[D], m_r2[D];
  logic [DW-1:0] m_v1[D], m_v2[D], m_imm[D];
  longint      m_seq[D];
  longint      seq_ctr;
  bit          m_isv[NF];
  logic [OW-1:0] m_iop[NF];
  logic [PW-1:0] m_ird[NF];
  logic [DW-1:0] m_iv1[NF], m_iv2[NF], m_iimm[NF];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int m_count();
    int c = 0;
    for (int i = 0; i < D; i++) if (m_valid[i]) c++;
    return c;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < D; i++) m_valid[i] = 0;
    for (int f = 0; f < NF; f++) m_isv[f] = 0;
    seq_ctr = 0;
  endtask

  // Value a source gets: tag 0 is zero, else first CDB port carrying the tag, else the RF
  task automatic resolve(input logic [PW-1:0] tag, input bit rdy, input logic [DW-1:0] val,
                         output bit r, output logic [DW-1:0] v);
    bit hit = 0;
    r = rdy;
    v = val;
    for (int k = 0; k < NC; k++) begin
      if (!hit && cdb_valid[k] && cdb_tag[k*PW +: PW] == tag) begin
        hit = 1;
        r   = 1;
        v   = cdb_data[k*DW +: DW];
      end
    end
    if (tag == 0) begin
      r = 1;
      v = 0;
    end
  endtask

  task automatic model_step();
    int pick[NF];
    int fr;
    bit fire, r;
    logic [DW-1:0] v;
    fire = disp_valid && (m_count() != D) && !flush;
    if (flush) begin
      for (int i = 0; i < D; i++) m_valid[i] = 0;
      for (int f = 0; f < NF; f++) m_isv[f] = 0;
      return;
    end
    fr = -1;
    for (int i = 0; i < D; i++) if (!m_valid[i] && fr < 0) fr = i;
    for (int f = 0; f < NF; f++) begin
      pick[f] = -1;
      if (!m_isv[f] || iss_ready[f]) begin
        for (int i = 0; i < D; i++) begin
          if (m_valid[i] && m_r1[i] && m_r2[i] && m_fu[i] == f &&
              (pick[f] < 0 || (AGE && m_seq[i] < m_seq[pick[f]]))) pick[f] = i;
        end
        m_isv[f] = (pick[f] >= 0);
        if (pick[f] >= 0) begin
          m_iop[f]  = m_op[pick[f]];
          m_ird[f]  = m_rd[pick[f]];
          m_iv1[f]  = m_v1[pick[f]];
          m_iv2[f]  = m_v2[pick[f]];
          m_iimm[f] = m_imm[pick[f]];
          m_valid[pick[f]] = 0;
        end
      end
    end
    for (int i = 0; i < D; i++) begin
      if (m_valid[i] && !m_r1[i]) resolve(m_t1[i], 0, m_v1[i], m_r1[i], m_v1[i]);
      if (m_valid[i] && !m_r2[i]) resolve(m_t2[i], 0, m_v2[i], m_r2[i], m_v2[i]);
    end
    if (fire) begin
      m_valid[fr] = 1;
      m_fu[fr]    = int'(disp_fu);
      m_op[fr]    = disp_op;
      m_rd[fr]    = disp_rd;
      m_t1[fr]    = disp_rs1;
      m_t2[fr]    = disp_rs2;
      m_imm[fr]   = disp_imm;
      resolve(disp_rs1, disp_rs1_rdy, disp_rs1_val, r, v);
      m_r1[fr] = r;
      m_v1[fr] = v;
      resolve(disp_rs2, disp_rs2_rdy, disp_rs2_val, r, v);
      m_r2[fr] = r;
      m_v2[fr] = v;
      m_seq[fr] = seq_ctr++;
    end
  endtask

  task automatic check_all();
    chk("occupancy", 64'(occupancy), 64'(m_count()));
    chk("empty", 64'(empty), 64'(m_count() == 0));
    chk("disp_ready", 64'(disp_ready), 64'((m_count() != D) && !flush));
    for (int f = 0; f < NF; f++) begin
      chk("iss_valid", 64'(iss_valid[f]), 64'(m_isv[f]));
      if (m_isv[f] && iss_valid[f]) begin
        chk("iss_op", 64'(iss_op[f*OW +: OW]), 64'(m_iop[f]));
        chk("iss_rd", 64'(iss_rd[f*PW +: PW]), 64'(m_ird[f]));
        chk("iss_rs1_val", 64'(iss_rs1_val[f*DW +: DW]), 64'(m_iv1[f]));
        chk("iss_rs2_val", 64'(iss_rs2_val[f*DW +: DW]), 64'(m_iv2[f]));
        chk("iss_imm", 64'(iss_imm[f*DW +: DW]), 64'(m_iimm[f]));
      end
    end
  endtask

  // Model consumes this cycle's inputs, clock edge, then compare at the falling edge
  task automatic cycle();
    model_step();
    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask

  task automatic idle();
    disp_valid = 0;
    cdb_valid  = '0;
    flush      = 0;
  endtask

  task automatic set_disp(input int fu, input int rd, input int rs1, input bit r1,
                          input int v1, input int rs2, input bit r2, input int v2);
    disp_valid   = 1;
    disp_op      = OW'(rd);
    disp_fu      = 2'(fu);
    disp_rd      = PW'(rd);
    disp_rs1     = PW'(rs1);
    disp_rs1_rdy = r1;
    disp_rs1_val = DW'(v1);
    disp_rs2     = PW'(rs2);
    disp_rs2_rdy = r2;
    disp_rs2_val = DW'(v2);
    disp_imm     = DW'(rd * 3);
  endtask

  task automatic set_cdb(input int k, input int tag, input int data);
    cdb_valid[k]           = 1'b1;
    cdb_tag[k*PW +: PW]    = PW'(tag);
    cdb_data[k*DW +: DW]   = DW'(data);
  endtask

  initial begin
    rst = 1;
    idle();
    iss_ready = '1;
    set_disp(0, 0, 0, 0, 0, 0, 0, 0);
    disp_valid = 0;
    cdb_tag = '0;
    cdb_data = '0;
    m_reset();
    @(negedge clk);
    @(negedge clk);
    chk("reset_iss_valid", 64'(iss_valid), 64'(0));
    chk("reset_occupancy", 64'(occupancy), 64'(0));
    chk("reset_empty", 64'(empty), 64'(1));
    chk("reset_disp_ready", 64'(disp_ready), 64'(1));
    chk("reset_iss_rs1_val", 64'(iss_rs1_val[DW-1:0]), 64'(0));
    rst = 0;
    check_all();

    // Plain ready dispatch issues one cycle later
    set_disp(0, 5, 1, 1, 10, 2, 1, 20);
    cycle();
    chk("t1_occ_after_disp", 64'(occupancy), 64'(1));
    idle();
    cycle();
    chk("t1_iss_valid0", 64'(iss_valid[0]), 64'(1));
    chk("t1_rs1_val", 64'(iss_rs1_val[DW-1:0]), 64'(10));
    chk("t1_rs2_val", 64'(iss_rs2_val[DW-1:0]), 64'(20));
    chk("t1_rd", 64'(iss_rd[PW-1:0]), 64'(5));
    chk("t1_occ_after_issue", 64'(occupancy), 64'(0));
    cycle();

    // Wakeup from CDB port 2 two cycles after dispatch
    set_disp(0, 6, 7, 0, 0, 0, 0, 'h123);
    cycle();
    idle();
    cycle();
    set_cdb(2, 7, 'h55);
    cycle();
    idle();
    chk("t2_not_yet", 64'(iss_valid[0]), 64'(0));
    cycle();
    chk("t2_iss_valid0", 64'(iss_valid[0]), 64'(1));
    chk("t2_rs1_val", 64'(iss_rs1_val[DW-1:0]), 64'('h55));
    chk("t2_rs2_tag0", 64'(iss_rs2_val[DW-1:0]), 64'(0));
    cycle();

    // Bypass: CDB tag matches on the dispatch cycle
    set_disp(2, 7, 0, 0, 0, 9, 0, 1);
    set_cdb(0, 9, 'hAA);
    cycle();
    idle();
    cycle();
    chk("t3_iss_valid2", 64'(iss_valid[2]), 64'(1));
    chk("t3_rs2_val", 64'(iss_rs2_val[2*DW +: DW]), 64'('hAA));
    chk("t3_rd", 64'(iss_rd[2*PW +: PW]), 64'(7));
    cycle();

    // Select policy: older entry in a higher slot than a younger ready one
    iss_ready[1] = 0;
    set_disp(1, 10, 0, 1, 0, 0, 1, 0);
    cycle();
    set_disp(1, 8, 3, 0, 0, 0, 1, 0);
    cycle();
    chk("age_first_issue", 64'(iss_rd[PW +: PW]), 64'(10));
    set_disp(1, 9, 0, 1, 0, 0, 1, 0);
    cycle();
    idle();
    set_cdb(0, 3, 'h33);
    cycle();
    idle();
    iss_ready[1] = 1;
    cycle();
    chk("age_select_rd", 64'(iss_rd[PW +: PW]), AGE ? 64'(8) : 64'(9));
    iss_ready = '1;
    for (int i = 0; i < 4; i++) cycle();

    // Fill to capacity with issue stalled
    iss_ready = '0;
    flush = 1;
    cycle();
    flush = 0;
    for (int i = 0; i < 20; i++) begin
      set_disp(0, i + 1, 0, 1, i, 0, 1, i);
      cycle();
    end
    chk("full_occ", 64'(occupancy), 64'(16));
    chk("full_disp_ready", 64'(disp_ready), 64'(0));
    idle();
    iss_ready[0] = 1;
    cycle();
    chk("drain_occ", 64'(occupancy), 64'(15));
    chk("drain_disp_ready", 64'(disp_ready), 64'(1));

    // Flush drops everything including a same-cycle dispatch
    iss_ready = '0;
    set_disp(1, 3, 0, 1, 0, 0, 1, 0);
    flush = 1;
    #1;
    chk("flush_blocks_ready", 64'(disp_ready), 64'(0));
    cycle();
    chk("flush_occ", 64'(occupancy), 64'(0));
    chk("flush_iss_valid", 64'(iss_valid), 64'(0));
    chk("flush_empty", 64'(empty), 64'(1));
    idle();
    cycle();
    chk("flush_disp_dropped", 64'(occupancy), 64'(0));

    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      disp_valid   = ($urandom_range(0, 9) < 7);
      disp_op      = OW'($urandom);
      disp_fu      = 2'($urandom_range(0, NF - 1));
      disp_rd      = PW'($urandom);
      disp_rs1     = PW'($urandom_range(0, 15));
      disp_rs2     = PW'($urandom_range(0, 15));
      disp_rs1_rdy = ($urandom_range(0, 9) < 4);
      disp_rs2_rdy = ($urandom_range(0, 9) < 4);
      disp_rs1_val = $urandom;
      disp_rs2_val = $urandom;
      disp_imm     = $urandom;
      for (int k = 0; k < NC; k++) begin
        cdb_valid[k]         = 1'($urandom_range(0, 1));
        cdb_tag[k*PW +: PW]  = PW'($urandom_range(1, 15));
        cdb_data[k*DW +: DW] = $urandom;
      end
      iss_ready = NF'($urandom);
      flush     = ($urandom_range(0, 99) < 2);
      cycle();
      if (c == 1500) begin
        #2 rst = 1;
        #1 m_reset();
        check_all();
        chk("midreset_occ", 64'(occupancy), 64'(0));
        @(negedge clk);
        rst = 0;
        check_all();
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/issue_queue_multi.md
Name: issue_queue_multi

Overview:
- Parametrised successor to the unified issue queue: RS_DEPTH entries, NUM_FU issue ports and NUM_CDB result-broadcast (wakeup) ports.
- Sits between rename/dispatch and the functional units.
- Adds a valid/ready dispatch handshake with back-pressure, per-FU issue handshakes, wakeup bypass on the dispatch cycle, and a pipeline flush.
- Oldest-first select is optional.

Parameters:
- RS_DEPTH, 16, number of entries (power of 2, 4..64)
- PREG_W, 6, physical register tag width
- DATA_W, 32, operand width
- NUM_FU, 3, issue ports / FUs (1..4)
- NUM_CDB, 3, wakeup/broadcast ports (1..4)
- OP_W, 4, operation code width

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- flush  in  1  synchronous; clears all entries and issue registers
- disp_valid  in  1  dispatch request
- disp_ready  out  1  queue can accept this cycle
- disp_op  in  OP_W  operation code
- disp_fu  in  2  target FU index (< NUM_FU)
- disp_rd  in  PREG_W  destination tag
- disp_rs1 / disp_rs2  in  PREG_W  source tags
- disp_rs1_rdy / disp_rs2_rdy  in  1  source ready per scoreboard
- disp_rs1_val / disp_rs2_val  in  DATA_W  register-file values
- disp_imm  in  DATA_W  immediate
- cdb_valid  in  NUM_CDB  broadcast valid per port
- cdb_tag  in  NUM_CDB*PREG_W  broadcast tags, port k at [k*PREG_W +: PREG_W]
- cdb_data  in  NUM_CDB*DATA_W  broadcast values
- iss_valid  out  NUM_FU  issue slot f holds an instruction
- iss_ready  in  NUM_FU  FU f accepts this cycle
- iss_op  out  NUM_FU*OP_W  issued op, per FU
- iss_rd  out  NUM_FU*PREG_W  issued destination tag
- iss_rs1_val / iss_rs2_val  out  NUM_FU*DATA_W  operand values
- iss_imm  out  NUM_FU*DATA_W  immediate
- occupancy  out  $clog2(RS_DEPTH+1)  valid entries
- empty  out  1  occupancy == 0

Behaviour:
- Reset (async, rst=1): all entries invalid; every iss_* output 0; occupancy 0; empty 1; disp_ready 1; age state cleared.
- disp_ready = (occupancy != RS_DEPTH) && !flush.
  - Depends only on registered state, not on disp_valid.
  - A slot freed by an issue in the same cycle is not counted.
- Dispatch fires on disp_valid && disp_ready and writes the lowest-index free entry at that edge.
- Source ready at write:
  - ready if disp_rsX_rdy, or tag == 0 (tag 0 is hardwired ready with value 0), or any cdb_valid[k] with cdb_tag[k] == tag (dispatch bypass).
  - The value comes from the CDB when bypassed, else from disp_rsX_val.
- Wakeup: each valid entry whose not-ready source tag matches a valid CDB port becomes ready at the edge and captures cdb_data. If several ports match, the lowest k wins.
- Select:
  - An entry is eligible when valid, both sources ready, and it is not being written this cycle. Minimum latency from dispatch to iss_valid is 1 cycle.
  - Per FU f, the slot loads when !iss_valid[f] || iss_ready[f]. One eligible entry with fu == f is chosen, lowest index (see optional feature).
  - At the load edge the chosen entry is freed and its fields are registered onto the port-f outputs with iss_valid[f]=1.
  - iss_valid[f] stays high with stable payload until iss_ready[f].
  - If no candidate exists, iss_valid[f] drops after the handshake.
- A wakeup and select for the same entry in the same cycle is not allowed. Wakeup takes effect next cycle, so the minimum wakeup-to-issue time is 1 cycle.
- Occupancy: +1 on dispatch, −1 per issued entry; simultaneous dispatch and issue nets correctly.
- Flush: at the next edge all entries are invalid, iss_valid = 0, occupancy = 0. Flush overrides a same-cycle dispatch and issue loads.
- Reset mid-operation clears everything immediately, regardless of handshakes.
- disp_fu ≥ NUM_FU is illegal: simulation assertion, entry behaviour undefined.

Optional Feature:
- Macro: IQ_AGE_SELECT_EN.
- Defined:
  - Keep an RS_DEPTH×RS_DEPTH age matrix; a dispatched entry is marked younger than all valid entries.
  - Select picks the oldest eligible entry per FU.
- Undefined:
  - No age matrix; select is lowest-index among eligible entries.
  - All other behaviour is identical.

Test Plan:
- Reset, then dispatch ADD rd=5 rs1=1(rdy,val=10) rs2=2(rdy,val=20) fu=0 → next cycle iss_valid[0]=1, rs1_val=10, rs2_val=20, rd=5; occupancy 1→0 on issue.
- Dispatch rs1=7 not ready; CDB port 2 broadcasts tag 7, data 0x55 two cycles later → iss_valid rises the cycle after the broadcast with rs1_val=0x55.
- Dispatch rs2=9 not ready in the same cycle as cdb tag 9, data 0xAA → entry ready at write; issues next cycle with rs2_val=0xAA.
- Fill 16 entries with iss_ready=0 → disp_ready=0 at occupancy 16; further disp_valid is ignored; raise iss_ready[0] → the occupancy-16 cycle frees one slot, disp_ready=1 the following cycle.
- With IQ_AGE_SELECT_EN: dispatch A (waits on tag 3) into entry 0, then B (ready) into entry 1 for fu 1, then wake A → B issues first; once both are eligible, the older one wins.
- flush asserted with 5 valid entries and iss_valid=3'b011 → next cycle occupancy=0, iss_valid=0, empty=1; a dispatch in the flush cycle is dropped.
